display_scheduler: RTL and testbench

Time-shares the board display between four requesters (clock, alarm, counter, message sources) ahead of the display controller. Grants one requester at a time for a fixed dwell measured in ticks, rotates round-robin among active requesters, and inserts a one-cycle blank gap between owners. Outputs a one-hot grant, a source select for the display mux, and a slot-start pulse that restarts the downstream display sequencer.

---
 rtl/display_pkg.sv | 27 ++
 rtl/display_rr_picker.sv | 27 ++
 rtl/display_scheduler.sv | 172 +++++++++++++++++
 tb/tb_display_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display time-share scheduler.
// Build option: DISPLAY_SCHED_URGENT_EN makes source 0 preempt other owners.
package display_pkg;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    localparam logic [SRC_W-1:0] SRC_CLOCK   = 2'd0;
    localparam logic [SRC_W-1:0] SRC_ALARM   = 2'd1;
    localparam logic [SRC_W-1:0] SRC_COUNTER = 2'd2;
    localparam logic [SRC_W-1:0] SRC_MSG     = 2'd3;

    // Request line 0 is the preempting one when the urgent build is enabled.
    localparam logic [SRC_W-1:0] URGENT_SRC  = 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
        src_onehot      = '0;
        src_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/display_rr_picker.sv
// Round-robin winner search: first asserted request after the last grantee,
// wrapping so the last grantee itself is considered last.
module display_rr_picker
    import display_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   winner,
    output logic               valid
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = last + SRC_W'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the display between four level requesters with a fixed dwell,
// round-robin rotation and a one-cycle blank gap. Option: DISPLAY_SCHED_URGENT_EN.
module display_scheduler
    import display_pkg::*;
#(
    parameter int TICK_DIV    = 100000000,
    parameter int DWELL_TICKS = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               display_en,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_W-1:0]   sel,
    output logic               blank,
    output logic               slot_start,
    output state_t             state_dbg
);

    localparam int CYC_W  = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int TICK_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DWELL_TICKS - 1);

    // Handshake: a source holds req high while it wants the display; it owns
    // the display exactly while its gnt bit is high and must not assume
    // ownership on any other cycle. Dropping req releases the slot early.

    state_t              state, state_n;
    logic [SRC_W-1:0]    last, last_n;
    logic [SRC_W-1:0]    sel_n;
    logic [NUM_SRC-1:0]  gnt_n;
    logic                blank_n, slot_start_n;
    logic [CYC_W-1:0]    cyc, cyc_n;
    logic [TICK_W-1:0]   tick, tick_n;

    logic [SRC_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                dwell_end;
    logic                urgent_hit;
    logic                do_grant;
    logic                keep_last;
    logic [SRC_W-1:0]    grant_idx;

    display_rr_picker u_picker (
        .req    (req),
        .last   (last),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign dwell_end = (cyc == CYC_LAST) && (tick == TICK_LAST);
    assign state_dbg = state;

`ifdef DISPLAY_SCHED_URGENT_EN
    logic urg_pend, urg_pend_n;
    assign urgent_hit = (sel != URGENT_SRC) && req[URGENT_SRC];
`else
    assign urgent_hit = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        last_n       = last;
        sel_n        = sel;
        gnt_n        = gnt;
        blank_n      = blank;
        slot_start_n = 1'b0;
        cyc_n        = cyc;
        tick_n       = tick;
        do_grant     = 1'b0;
        keep_last    = 1'b0;
        grant_idx    = pick_idx;
`ifdef DISPLAY_SCHED_URGENT_EN
        urg_pend_n   = urg_pend;
`endif
        case (state)
            IDLE: begin
                gnt_n   = '0;
                blank_n = 1'b1;
`ifdef DISPLAY_SCHED_URGENT_EN
                urg_pend_n = 1'b0;
`endif
                if (display_en && pick_valid) do_grant = 1'b1;
            end
            GRANT: begin
                if (!display_en) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    blank_n = 1'b1;
`ifdef DISPLAY_SCHED_URGENT_EN
                    urg_pend_n = 1'b0;
`endif
                end else if (!req[sel] || dwell_end || urgent_hit) begin
                    state_n = GAP;
                    gnt_n   = '0;
                    blank_n = 1'b1;
`ifdef DISPLAY_SCHED_URGENT_EN
                    urg_pend_n = urgent_hit;
`endif
                end else if (cyc == CYC_LAST) begin
                    cyc_n = '0;
                    if (tick != TICK_LAST) tick_n = tick + 1'b1;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            GAP: begin
                gnt_n   = '0;
                blank_n = 1'b1;
                state_n = IDLE;
`ifdef DISPLAY_SCHED_URGENT_EN
                urg_pend_n = 1'b0;
                // A preempted slot hands over to the urgent source without
                // moving the rotation pointer.
                if (urg_pend && req[URGENT_SRC]) begin
                    grant_idx = URGENT_SRC;
                    keep_last = 1'b1;
                end
`endif
                if (display_en && pick_valid) do_grant = 1'b1;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                blank_n = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_n      = GRANT;
            sel_n        = grant_idx;
            gnt_n        = src_onehot(grant_idx);
            blank_n      = 1'b0;
            slot_start_n = 1'b1;
            cyc_n        = '0;
            tick_n       = '0;
            if (!keep_last) last_n = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 2'd3;
            sel        <= '0;
            gnt        <= '0;
            blank      <= 1'b1;
            slot_start <= 1'b0;
            cyc        <= '0;
            tick       <= '0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            sel        <= sel_n;
            gnt        <= gnt_n;
            blank      <= blank_n;
            slot_start <= slot_start_n;
            cyc        <= cyc_n;
            tick       <= tick_n;
        end
    end

`ifdef DISPLAY_SCHED_URGENT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) urg_pend <= 1'b0;
        else     urg_pend <= urg_pend_n;
    end
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (TICK_DIV=4, DWELL_TICKS=2): every
// finished grant run is scored against an expected {length, grant} queue.
module tb_display_scheduler;
    import display_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         display_en;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         blank;
    logic         slot_start;
    state_t       state_dbg;

    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    logic [11:0]  exp_q[$];
    logic [3:0]   prev_gnt = 4'b0000;
    int           run_len  = 0;

    display_scheduler #(.TICK_DIV(4), .DWELL_TICKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .display_en (display_en),
        .req        (req),
        .gnt        (gnt),
        .sel        (sel),
        .blank      (blank),
        .slot_start (slot_start),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] slot(input int len, input logic [3:0] g);
        return {8'(len), g};
    endfunction

    // Scoreboard: score each grant run when it ends, check slot_start when it begins.
    always @(negedge clk) begin
        if (gnt !== prev_gnt) begin
            if (prev_gnt !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $error("FAIL sb_empty: observed run %0h len %0d expected none", prev_gnt, run_len);
                end else begin
                    check("sb_slot", {8'(run_len), prev_gnt}, exp_q.pop_front());
                end
            end
            if (gnt !== 4'b0000) begin
                check("slot_start_on_rise", slot_start, 1);
                run_len = 1;
            end
        end else if (gnt !== 4'b0000) begin
            run_len++;
        end
        prev_gnt = gnt;
    end

    initial begin
        rst = 1'b0; display_en = 1'b0; req = 4'b0000;
        #1 rst = 1'b1;
        step(2);
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_blank", blank, 1);
        check("rst_slot_start", slot_start, 0);
        check("rst_state", state_dbg, IDLE);

`ifdef DISPLAY_SCHED_URGENT_EN
        exp_q.push_back(slot(2, 4'b0100));
        exp_q.push_back(slot(8, 4'b0001));
        exp_q.push_back(slot(1, 4'b1000));
        req = 4'b0100; display_en = 1'b1; rst = 1'b0;
        step(1);
        check("urg_src2", gnt, 4'b0100);
        step(1);
        req = 4'b1111;
        step(1);
        check("urg_gap_gnt", gnt, 0);
        check("urg_gap_blank", blank, 1);
        step(1);
        check("urg_src0", gnt, 4'b0001);
        step(8);
        check("urg_gap2", gnt, 0);
        step(1);
        check("urg_next_src3", gnt, 4'b1000);
        check("urg_next_sel", sel, 3);
        display_en = 1'b0;
        step(1);
        check("urg_off", gnt, 0);
`else
        exp_q.push_back(slot(8, 4'b0001));
        exp_q.push_back(slot(8, 4'b0010));
        exp_q.push_back(slot(8, 4'b0100));
        exp_q.push_back(slot(8, 4'b1000));
        exp_q.push_back(slot(1, 4'b0001));
        req = 4'b1111; display_en = 1'b1; rst = 1'b0;
        step(1);
        check("first_gnt", gnt, 4'b0001);
        check("first_ss", slot_start, 1);
        check("first_blank", blank, 0);
        check("first_state", state_dbg, GRANT);
        step(1);
        check("ss_one_cycle", slot_start, 0);
        step(7);
        check("gap_gnt", gnt, 0);
        check("gap_blank", blank, 1);
        check("gap_sel_hold", sel, 0);
        step(1);
        check("rot_gnt1", gnt, 4'b0010);
        check("rot_sel1", sel, 1);
        step(27);
        check("rot_wrap", gnt, 4'b0001);

        // Lone requester 2 after source 0 releases early.
        exp_q.push_back(slot(8, 4'b0100));
        exp_q.push_back(slot(8, 4'b0100));
        exp_q.push_back(slot(3, 4'b0100));
        req = 4'b0100;
        step(1);
        check("drop_gap", gnt, 0);
        step(1);
        check("lone_gnt", gnt, 4'b0100);
        check("lone_ss0", slot_start, 1);
        step(1);
        check("lone_ss_low", slot_start, 0);
        step(8);
        check("lone_ss_period", slot_start, 1);
        step(9);
        check("lone_ss_period2", slot_start, 1);
        step(2);

        // Enable drop mid-slot, then resume from the pointer.
        display_en = 1'b0;
        step(1);
        check("en_off_gnt", gnt, 0);
        check("en_off_blank", blank, 1);
        check("en_off_state", state_dbg, IDLE);
        step(1);
        check("idle_hold", gnt, 0);
        exp_q.push_back(slot(3, 4'b1000));
        req = 4'b1111; display_en = 1'b1;
        step(1);
        check("resume_gnt", gnt, 4'b1000);
        check("resume_sel", sel, 3);
        step(2);

        // Asynchronous reset in the middle of a slot.
        #1 rst = 1'b1;
        #1;
        check("async_gnt", gnt, 0);
        check("async_sel", sel, 0);
        check("async_blank", blank, 1);
        check("async_ss", slot_start, 0);
        step(1);
        exp_q.push_back(slot(3, 4'b0001));
        exp_q.push_back(slot(1, 4'b0010));
        req = 4'b0011; rst = 1'b0;
        step(1);
        check("post_rst_src0", gnt, 4'b0001);
        step(2);
        req = 4'b0010;
        step(1);
        check("early_gap", gnt, 0);
        check("early_blank", blank, 1);
        step(1);
        check("early_next", gnt, 4'b0010);

        // Source 0 is an ordinary requester in this build.
        exp_q.push_back(slot(8, 4'b0100));
        exp_q.push_back(slot(1, 4'b1000));
        req = 4'b0100;
        step(2);
        check("plain_src2", gnt, 4'b0100);
        step(1);
        req = 4'b1111;
        step(6);
        check("plain_no_preempt", gnt, 4'b0100);
        step(1);
        check("plain_gap", gnt, 0);
        step(1);
        check("plain_next_src3", gnt, 4'b1000);
        display_en = 1'b0;
        step(1);
        check("plain_off", gnt, 0);
`endif

        step(2);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
